// File: rtl/dice_cfg_pkg.sv
// Shared types and helpers for the DICE tile multi-context configuration store.
package dice_cfg_pkg;

  // Default width of one tile configuration image.
  localparam int DEFAULT_CFG_W = 156;

  // Burst load controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

  // Words needed to cover one image: ceil(cfg_w / word_w).
  function automatic int calc_num_words(input int cfg_w, input int word_w);
    return (cfg_w + word_w - 1) / word_w;
  endfunction

  // Context index width, never narrower than one bit.
  function automatic int calc_ctx_w(input int num_ctx);
    return (num_ctx > 1) ? $clog2(num_ctx) : 1;
  endfunction

endpackage

// File: rtl/dice_cfg_assembler.sv
// Staging register that assembles a burst of stream words into one image.
// A start clears the staging image and writes word 0; each write stores the
// next word at the current count. Bits of the last word above CFG_W are dropped.
module dice_cfg_assembler
  import dice_cfg_pkg::*;
#(
  parameter int CFG_W  = DEFAULT_CFG_W,
  parameter int WORD_W = 32,
  localparam int NUM_WORDS = calc_num_words(CFG_W, WORD_W),
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr,
  input  logic [WORD_W-1:0] data,
  output logic [CFG_W-1:0]  staging,
  output logic              full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

  logic [CFG_W-1:0] staging_r;
  logic [CFG_W-1:0] base_s;
  logic [CFG_W-1:0] staging_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] idx_s;

  // Merge the incoming word into the (possibly cleared) staging image.
  always_comb begin
    base_s        = staging_r;
    idx_s         = count_r;
    staging_nxt_s = staging_r;
    if (start) begin
      base_s = '0;
      idx_s  = '0;
    end else begin
      base_s = staging_r;
      idx_s  = count_r;
    end
    staging_nxt_s = base_s;
    for (int b = 0; b < CFG_W; b++) begin
      if ((b / WORD_W) == int'(idx_s)) begin
        staging_nxt_s[b] = data[b % WORD_W];
      end else begin
        staging_nxt_s[b] = base_s[b];
      end
    end
  end

  // Staging image and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_r <= '0;
      count_r   <= '0;
    end else if (start) begin
      staging_r <= staging_nxt_s;
      count_r   <= CNT_W'(1);
    end else if (wr) begin
      staging_r <= staging_nxt_s;
      count_r   <= count_r + CNT_W'(1);
    end
  end

  assign staging = staging_r;
  assign full    = (count_r == FULL_CNT);

endmodule

// File: rtl/dice_tile_cfg_ctx.sv
// Multi-context DICE tile configuration store: burst loader FSM, per-context
// image store with valid flags, one-cycle context switch and active-image mux.
module dice_tile_cfg_ctx
  import dice_cfg_pkg::*;
#(
  parameter int CFG_W   = DEFAULT_CFG_W,
  parameter int WORD_W  = 32,
  parameter int NUM_CTX = 2,
  localparam int NUM_WORDS = calc_num_words(CFG_W, WORD_W),
  localparam int CTX_W     = calc_ctx_w(NUM_CTX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_in_valid,
  output logic               cfg_in_ready,
  input  logic [WORD_W-1:0]  cfg_in_data,
  input  logic [CTX_W-1:0]   cfg_in_ctx,
  input  logic               cfg_in_last,
  input  logic               ctx_sw_req,
  input  logic [CTX_W-1:0]   ctx_sw_id,
  output logic               ctx_sw_ack,
  output logic [CTX_W-1:0]   active_ctx,
  output logic [NUM_CTX-1:0] ctx_valid,
  output logic [CFG_W-1:0]   tile_cfg,
  output logic               load_done,
  output logic               cfg_err
);

  localparam logic [CTX_W:0] NUM_CTX_V = (CTX_W + 1)'(NUM_CTX);

  cfg_state_e         state_r;
  cfg_state_e         next_state_s;
  logic [CTX_W-1:0]   target_r;
  logic [CTX_W-1:0]   active_ctx_r;
  logic [NUM_CTX-1:0] ctx_valid_r;
  logic [CFG_W-1:0]   ctx_store_r [NUM_CTX];
  logic               ready_r;
  logic               load_done_r;
  logic               ack_r;
  logic               err_r;

  logic               accept_s;
  logic               load_bad_s;
  logic               sw_ok_s;
  logic               sw_err_s;
  logic               start_s;
  logic               wr_s;
  logic               load_err_s;
  logic               commit_s;
  logic               asm_full_s;
  logic [CFG_W-1:0]   staging_s;

  assign accept_s   = cfg_in_valid && ready_r;
  // Load target check uses the pre-switch active context.
  assign load_bad_s = ({1'b0, cfg_in_ctx} >= NUM_CTX_V) ||
                      ((cfg_in_ctx == active_ctx_r) && ctx_valid_r[active_ctx_r]);
  // Switch check uses the flags as they stand before this cycle's updates.
  assign sw_ok_s    = ({1'b0, ctx_sw_id} < NUM_CTX_V) && ctx_valid_r[ctx_sw_id];
  assign sw_err_s   = ctx_sw_req && !sw_ok_s;

  dice_cfg_assembler #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .wr      (wr_s),
    .data    (cfg_in_data),
    .staging (staging_s),
    .full    (asm_full_s)
  );

  // Load FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Load FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (load_bad_s) begin
            next_state_s = cfg_in_last ? ST_IDLE : ST_DRAIN;
          end else begin
            next_state_s = cfg_in_last ? ST_COMMIT : ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (asm_full_s) begin
            next_state_s = cfg_in_last ? ST_IDLE : ST_DRAIN;
          end else begin
            next_state_s = cfg_in_last ? ST_COMMIT : ST_LOAD;
          end
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (accept_s && cfg_in_last) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Load FSM output decode: assembler strobes, overflow/target errors, commit.
  always_comb begin
    start_s    = 1'b0;
    wr_s       = 1'b0;
    load_err_s = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          start_s    = !load_bad_s;
          load_err_s = load_bad_s;
        end else begin
          start_s    = 1'b0;
          load_err_s = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          wr_s       = !asm_full_s;
          load_err_s = asm_full_s;
        end else begin
          wr_s       = 1'b0;
          load_err_s = 1'b0;
        end
      end
      ST_DRAIN:  commit_s = 1'b0;
      ST_COMMIT: commit_s = 1'b1;
      default:   commit_s = 1'b0;
    endcase
  end

  // Latch the load target on the first word of an accepted burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r <= '0;
    end else if (start_s) begin
      target_r <= cfg_in_ctx;
    end
  end

  // Context store and valid flags: invalidate at burst start, fill at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_valid_r <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        ctx_store_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (commit_s && (target_r == CTX_W'(c))) begin
          ctx_store_r[c] <= staging_s;
          ctx_valid_r[c] <= 1'b1;
        end else if (start_s && (cfg_in_ctx == CTX_W'(c))) begin
          ctx_valid_r[c] <= 1'b0;
        end
      end
    end
  end

  // Context switch: update active context and acknowledge one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_ctx_r <= '0;
      ack_r        <= 1'b0;
    end else begin
      if (ctx_sw_req && sw_ok_s) begin
        active_ctx_r <= ctx_sw_id;
      end
      ack_r <= ctx_sw_req && sw_ok_s;
    end
  end

  // Registered handshake and status pulses; both error sources merge into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b1;
      load_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      ready_r     <= (next_state_s != ST_COMMIT);
      load_done_r <= (next_state_s == ST_COMMIT);
      err_r       <= load_err_s || sw_err_s;
    end
  end

  assign cfg_in_ready = ready_r;
  assign load_done    = load_done_r;
  assign cfg_err      = err_r;
  assign ctx_sw_ack   = ack_r;
  assign active_ctx   = active_ctx_r;
  assign ctx_valid    = ctx_valid_r;
  assign tile_cfg     = ctx_store_r[active_ctx_r];

endmodule

// File: tb/tb_dice_tile_cfg_ctx.sv
// Directed self-checking bench for dice_tile_cfg_ctx (default parameters).
module tb_dice_tile_cfg_ctx;

  logic         clk;
  logic         rst_n;
  logic         cfg_in_valid;
  logic         cfg_in_ready;
  logic [31:0]  cfg_in_data;
  logic [0:0]   cfg_in_ctx;
  logic         cfg_in_last;
  logic         ctx_sw_req;
  logic [0:0]   ctx_sw_id;
  logic         ctx_sw_ack;
  logic [0:0]   active_ctx;
  logic [1:0]   ctx_valid;
  logic [155:0] tile_cfg;
  logic         load_done;
  logic         cfg_err;

  int checks;
  int errors;

  logic [155:0] img0;
  logic [155:0] img1;
  logic [155:0] img_short;
  logic [155:0] img_one;

  dice_tile_cfg_ctx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_ready (cfg_in_ready),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_ctx   (cfg_in_ctx),
    .cfg_in_last  (cfg_in_last),
    .ctx_sw_req   (ctx_sw_req),
    .ctx_sw_id    (ctx_sw_id),
    .ctx_sw_ack   (ctx_sw_ack),
    .active_ctx   (active_ctx),
    .ctx_valid    (ctx_valid),
    .tile_cfg     (tile_cfg),
    .load_done    (load_done),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word for one clock edge; returns 1 time unit after the edge.
  task automatic drive_word(input logic [31:0] d, input logic [0:0] c, input logic l);
    cfg_in_valid = 1'b1;
    cfg_in_data  = d;
    cfg_in_ctx   = c;
    cfg_in_last  = l;
    @(posedge clk); #1;
    cfg_in_valid = 1'b0;
    cfg_in_last  = 1'b0;
  endtask

  // Issue a one-cycle switch request.
  task automatic drive_switch(input logic [0:0] id);
    ctx_sw_req = 1'b1;
    ctx_sw_id  = id;
    @(posedge clk); #1;
    ctx_sw_req = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cfg_in_valid = 1'b0; cfg_in_data = 32'h0; cfg_in_ctx = 1'b0; cfg_in_last = 1'b0;
    ctx_sw_req = 1'b0; ctx_sw_id = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (cfg_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_in_ready); end
    checks++; if (ctx_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", ctx_valid); end
    checks++; if (tile_cfg !== 156'd0) begin errors++; $display("FAIL reset_tile got %h exp 0", tile_cfg); end
    checks++; if ({active_ctx, load_done, cfg_err, ctx_sw_ack} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {active_ctx, load_done, cfg_err, ctx_sw_ack}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_ctx0();
    drive_word(32'h11111111, 1'b0, 1'b0);
    checks++; if (ctx_valid !== 2'b00) begin errors++; $display("FAIL t1_valid_during got %b exp 00", ctx_valid); end
    drive_word(32'h22222222, 1'b0, 1'b0);
    drive_word(32'h33333333, 1'b0, 1'b0);
    checks++; if (tile_cfg !== 156'd0 || load_done !== 1'b0) begin errors++; $display("FAIL t1_mid got tile %h done %b exp 0 0", tile_cfg, load_done); end
    drive_word(32'h44444444, 1'b0, 1'b0);
    drive_word(32'h55555555, 1'b0, 1'b1);
    // Now in the commit cycle (cycle 6 of the burst).
    checks++; if (load_done !== 1'b1 || cfg_in_ready !== 1'b0) begin errors++; $display("FAIL t1_commit got done %b ready %b exp 1 0", load_done, cfg_in_ready); end
    idle_cycle();
    checks++; if (load_done !== 1'b0 || cfg_in_ready !== 1'b1) begin errors++; $display("FAIL t1_after got done %b ready %b exp 0 1", load_done, cfg_in_ready); end
    checks++; if (ctx_valid !== 2'b01) begin errors++; $display("FAIL t1_valid got %b exp 01", ctx_valid); end
    checks++; if (tile_cfg[31:0] !== 32'h11111111 || tile_cfg[155:128] !== 28'h5555555) begin errors++; $display("FAIL t1_edges got %h exp 5555555..11111111", tile_cfg); end
    checks++; if (tile_cfg !== img0) begin errors++; $display("FAIL t1_image got %h exp %h", tile_cfg, img0); end
  endtask

  task automatic test_switch();
    for (int i = 0; i < 5; i++) drive_word(32'hA5A5A5A5, 1'b1, (i == 4) ? 1'b1 : 1'b0);
    checks++; if (tile_cfg !== img0) begin errors++; $display("FAIL t2_bg_load got %h exp %h", tile_cfg, img0); end
    idle_cycle();
    checks++; if (ctx_valid !== 2'b11) begin errors++; $display("FAIL t2_valid got %b exp 11", ctx_valid); end
    drive_switch(1'b1);
    checks++; if (ctx_sw_ack !== 1'b1 || active_ctx !== 1'b1 || cfg_err !== 1'b0) begin errors++; $display("FAIL t2_ack got ack %b act %b err %b exp 1 1 0", ctx_sw_ack, active_ctx, cfg_err); end
    checks++; if (tile_cfg !== img1) begin errors++; $display("FAIL t2_tile got %h exp %h", tile_cfg, img1); end
    idle_cycle();
    checks++; if (ctx_sw_ack !== 1'b0) begin errors++; $display("FAIL t2_ack_pulse got %b exp 0", ctx_sw_ack); end
    drive_switch(1'b0);
    checks++; if (ctx_sw_ack !== 1'b1 || tile_cfg !== img0) begin errors++; $display("FAIL t2_back got ack %b tile %h exp 1 %h", ctx_sw_ack, tile_cfg, img0); end
    drive_switch(1'b0);
    checks++; if (ctx_sw_ack !== 1'b1 || active_ctx !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL t2_same got ack %b act %b err %b exp 1 0 0", ctx_sw_ack, active_ctx, cfg_err); end
  endtask

  task automatic test_reject_active();
    drive_word(32'hBAD00001, 1'b0, 1'b0);
    checks++; if (cfg_err !== 1'b1 || cfg_in_ready !== 1'b1) begin errors++; $display("FAIL t3_err got err %b ready %b exp 1 1", cfg_err, cfg_in_ready); end
    drive_word(32'hBAD00002, 1'b0, 1'b0);
    checks++; if (cfg_err !== 1'b0 || cfg_in_ready !== 1'b1) begin errors++; $display("FAIL t3_drain got err %b ready %b exp 0 1", cfg_err, cfg_in_ready); end
    drive_word(32'hBAD00003, 1'b0, 1'b1);
    checks++; if (load_done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL t3_last got done %b err %b exp 0 0", load_done, cfg_err); end
    idle_cycle();
    checks++; if (tile_cfg !== img0 || ctx_valid !== 2'b11) begin errors++; $display("FAIL t3_store got %h %b exp %h 11", tile_cfg, ctx_valid, img0); end
  endtask

  task automatic test_short_burst();
    drive_word(32'hDEADBEEF, 1'b1, 1'b0);
    checks++; if (ctx_valid !== 2'b01) begin errors++; $display("FAIL t4_invalidate got %b exp 01", ctx_valid); end
    // Second word and a switch to the context under load in the same cycle.
    cfg_in_valid = 1'b1; cfg_in_data = 32'hCAFEF00D; cfg_in_ctx = 1'b1; cfg_in_last = 1'b1;
    ctx_sw_req = 1'b1; ctx_sw_id = 1'b1;
    @(posedge clk); #1;
    cfg_in_valid = 1'b0; cfg_in_last = 1'b0; ctx_sw_req = 1'b0;
    checks++; if (cfg_err !== 1'b1 || ctx_sw_ack !== 1'b0 || active_ctx !== 1'b0) begin errors++; $display("FAIL t4_sw_rej got err %b ack %b act %b exp 1 0 0", cfg_err, ctx_sw_ack, active_ctx); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL t4_done got %b exp 1", load_done); end
    idle_cycle();
    drive_switch(1'b1);
    checks++; if (ctx_sw_ack !== 1'b1 || tile_cfg !== img_short) begin errors++; $display("FAIL t4_image got ack %b tile %h exp 1 %h", ctx_sw_ack, tile_cfg, img_short); end
    drive_switch(1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      drive_word(32'(i), 1'b1, 1'b0);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL t5_word%0d got err %b exp 0", i, cfg_err); end
    end
    drive_word(32'h00000006, 1'b1, 1'b1);
    checks++; if (cfg_err !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL t5_ovf got err %b done %b exp 1 0", cfg_err, load_done); end
    checks++; if (ctx_valid !== 2'b01 || cfg_in_ready !== 1'b1) begin errors++; $display("FAIL t5_state got valid %b ready %b exp 01 1", ctx_valid, cfg_in_ready); end
    drive_switch(1'b1);
    checks++; if (cfg_err !== 1'b1 || load_done !== 1'b0 || active_ctx !== 1'b0) begin errors++; $display("FAIL t5_sw got err %b done %b act %b exp 1 0 0", cfg_err, load_done, active_ctx); end
  endtask

  task automatic test_async_reset();
    drive_word(32'h12345678, 1'b1, 1'b1);
    idle_cycle();
    drive_switch(1'b1);
    checks++; if (active_ctx !== 1'b1 || tile_cfg !== img_one) begin errors++; $display("FAIL t6_single got act %b tile %h exp 1 %h", active_ctx, tile_cfg, img_one); end
    drive_word(32'h0F0F0F0F, 1'b0, 1'b0);
    drive_word(32'hF0F0F0F0, 1'b0, 1'b0);
    checks++; if (ctx_valid !== 2'b10) begin errors++; $display("FAIL t6_loading got %b exp 10", ctx_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cfg_in_ready !== 1'b1 || ctx_valid !== 2'b00) begin errors++; $display("FAIL t6_rst_a got ready %b valid %b exp 1 00", cfg_in_ready, ctx_valid); end
    checks++; if (tile_cfg !== 156'd0 || active_ctx !== 1'b0) begin errors++; $display("FAIL t6_rst_b got tile %h act %b exp 0 0", tile_cfg, active_ctx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_switch(1'b1);
    checks++; if (cfg_err !== 1'b1 || active_ctx !== 1'b0) begin errors++; $display("FAIL t6_cleared got err %b act %b exp 1 0", cfg_err, active_ctx); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    img0      = {28'h5555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    img1      = {28'h5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    img_short = {92'd0, 32'hCAFEF00D, 32'hDEADBEEF};
    img_one   = {124'd0, 32'h12345678};
    test_reset();
    test_load_ctx0();
    test_switch();
    test_reject_active();
    test_short_burst();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
